// File: rtl/kudu_dv_pkg.sv
// Shared types and constants for the testbench data-bus arbiter slice.
package kudu_dv_pkg;

    // Identifies which upstream master owns a transaction.
    typedef enum logic {
        MST_LSU  = 1'b0,
        MST_STKZ = 1'b1
    } bus_mst_id_e;

    // Arbiter address-phase state: free to arbitrate, or holding an ungranted request.
    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    localparam int DBUS_ARB_MAX_OUT = 4;

    // Round-robin helper: the master that did not win last time.
    function automatic bus_mst_id_e other_mst(input bus_mst_id_e m);
        return (m == MST_LSU) ? MST_STKZ : MST_LSU;
    endfunction

endpackage

// File: rtl/dbus_id_fifo.sv
// In-order ID FIFO: remembers which master owns each granted-but-unanswered transaction.
module dbus_id_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 1,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // A pop frees the slot this cycle, so a push into a full FIFO is legal alongside it.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Pointer and occupancy update; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage write.
    always_ff @(posedge clk_i) begin
        // NOTE: storage is deliberately not reset; entries are only read after being written.
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/data_bus_arb.sv
// Two-master OBI data-bus arbiter with in-order response routing.
module data_bus_arb
    import kudu_dv_pkg::*;
#(
    parameter  int DW      = 65,
    parameter  int MAX_OUT = DBUS_ARB_MAX_OUT,
    localparam int CW      = $clog2(MAX_OUT) + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,

    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [3:0]    m0_be,
    input  logic          m0_is_cap,
    input  logic [31:0]   m0_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic [7:0]    m0_flag,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_err,

    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [3:0]    m1_be,
    input  logic          m1_is_cap,
    input  logic [31:0]   m1_addr,
    input  logic [DW-1:0] m1_wdata,
    input  logic [7:0]    m1_flag,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_err,

    output logic          data_req,
    output logic          data_we,
    output logic [3:0]    data_be,
    output logic          data_is_cap,
    output logic [31:0]   data_addr,
    output logic [DW-1:0] data_wdata,
    output logic [7:0]    data_flag,
    input  logic          data_gnt,
    input  logic          data_rvalid,
    input  logic [DW-1:0] data_rdata,
    input  logic          data_err,

    output logic [CW-1:0] outstanding_o,
    output logic          spurious_rsp_o
);

    arb_state_e  state_q, state_d;
    bus_mst_id_e lock_sel_q;
    bus_mst_id_e rr_last_q;
    bus_mst_id_e sel;
    bus_mst_id_e head_mst;

    logic          push;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [0:0]    fifo_head;
    logic          rsp_m0;
    logic          rsp_m1;

    assign push     = data_req & data_gnt;
    assign pop      = data_rvalid & ~fifo_empty;
    assign head_mst = bus_mst_id_e'(fifo_head);

    dbus_id_fifo #(
        .DEPTH (MAX_OUT),
        .WIDTH (1)
    ) u_id_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push      (push),
        .push_data (sel),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .head      (fifo_head)
    );

    // Selection and next state; once a request is presented it is held until granted.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_d  = state_q;
        sel      = lock_sel_q;
        data_req = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                // Registered occupancy gates selection, so a pending pop does not open a slot early.
                if (!fifo_full) begin
                    if (m0_req && m1_req) begin
                        sel      = other_mst(rr_last_q);
                        data_req = 1'b1;
                    end else if (m0_req) begin
                        sel      = MST_LSU;
                        data_req = 1'b1;
                    end else if (m1_req) begin
                        sel      = MST_STKZ;
                        data_req = 1'b1;
                    end
                end
            end
            ARB_LOCKED: begin
                sel      = lock_sel_q;
                data_req = 1'b1;
            end
        endcase
        if (data_req) state_d = data_gnt ? ARB_IDLE : ARB_LOCKED;
    end

    // Arbiter state, lock owner, round-robin history and the sticky spurious-response flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= ARB_IDLE;
            lock_sel_q     <= MST_LSU;
            rr_last_q      <= MST_STKZ;
            spurious_rsp_o <= 1'b0;
        end else begin
            state_q <= state_d;
            if (data_req)                  lock_sel_q     <= sel;
            if (push)                      rr_last_q      <= sel;
            if (data_rvalid && fifo_empty) spurious_rsp_o <= 1'b1;
        end
    end

    // Address-phase attribute mux follows the current selection.
    always_comb begin
        if (sel == MST_STKZ) begin
            data_we     = m1_we;
            data_be     = m1_be;
            data_is_cap = m1_is_cap;
            data_addr   = m1_addr;
            data_wdata  = m1_wdata;
            data_flag   = m1_flag;
        end else begin
            data_we     = m0_we;
            data_be     = m0_be;
            data_is_cap = m0_is_cap;
            data_addr   = m0_addr;
            data_wdata  = m0_wdata;
            data_flag   = m0_flag;
        end
    end

    assign m0_gnt = push & (sel == MST_LSU);
    assign m1_gnt = push & (sel == MST_STKZ);

    // Responses go to the master at the FIFO head; the other master sees zeros.
    assign rsp_m0    = pop & (head_mst == MST_LSU);
    assign rsp_m1    = pop & (head_mst == MST_STKZ);
    assign m0_rvalid = rsp_m0;
    assign m1_rvalid = rsp_m1;
    assign m0_rdata  = rsp_m0 ? data_rdata : '0;
    assign m1_rdata  = rsp_m1 ? data_rdata : '0;
    assign m0_err    = rsp_m0 & data_err;
    assign m1_err    = rsp_m1 & data_err;

    assign outstanding_o = fifo_count;

endmodule
